// File: rtl/half_mat_v_sequencer_if.sv
// rtl/half_mat_v_sequencer_if.sv - signal bundle between layer control, row sequencer and dot unit
// Purpose: carries run control (start/busy/done/error), the dot-unit handshake
//   (row_sel/dot_start/dot_done/dot_c) and the stored row results
//   (row_valid/row_value/results).
// Modports: slave  = sequencer side (drives busy, done, error, row_sel, dot_start,
//                    row_valid, row_value, results; receives start, dot_done, dot_c)
//           master = environment side (layer FSM plus dot unit), the mirror image.
interface half_mat_v_sequencer_if #(
  parameter int ROWS = 4
);
  localparam int RW = $clog2(ROWS + 1);

  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [RW-1:0]         row_sel;
  logic                  dot_start;
  logic                  dot_done;
  logic [15:0]           dot_c;
  logic                  row_valid;
  logic [15:0]           row_value;
  logic [ROWS-1:0][15:0] results;

  modport slave (
    input  start, dot_done, dot_c,
    output busy, done, error, row_sel, dot_start, row_valid, row_value, results
  );

  modport master (
    output start, dot_done, dot_c,
    input  busy, done, error, row_sel, dot_start, row_valid, row_value, results
  );
endinterface

// File: rtl/half_mat_v_sequencer.sv
// rtl/half_mat_v_sequencer.sv - sequences one shared fp16 dot unit over ROWS matrix rows
// Purpose: per row, presents row_sel, pulses dot_start, waits for a fresh dot_done
//   and stores dot_c into results[row_sel]; aborts the run with a sticky error if a
//   row waits TIMEOUT cycles without dot_done.
// Ports: clk, rstn (sync active-low) plain; everything else through bus (slave):
//   start in, busy/done/error out, row_sel/dot_start out, dot_done/dot_c in,
//   row_valid/row_value/results out. All outputs are registered.
module half_mat_v_sequencer #(
  parameter int ROWS    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  half_mat_v_sequencer_if.slave bus
);
  localparam int RW = $clog2(ROWS + 1);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_STORE, S_FINISH
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic [RW-1:0]         r_row_sel;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic                  r_dot_start;
  logic                  r_row_valid;
  logic [15:0]           r_row_value;
  logic [ROWS-1:0][15:0] r_results;
  logic                  w_last_row;
  logic                  w_timeout;

  assign w_last_row = (r_row_sel == RW'(ROWS - 1));
  assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));

  // ARM exists only to let the previous row's done level (still high) go by
  // unseen; WAIT is the first state that looks at dot_done.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = S_ISSUE;
      S_ISSUE:  w_next = S_ARM;
      S_ARM:    w_next = S_WAIT;
      S_WAIT: begin
        if (bus.dot_done)   w_next = S_STORE;
        else if (w_timeout) w_next = S_FINISH;
      end
      S_STORE:  w_next = w_last_row ? S_FINISH : S_ISSUE;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registers that
  // line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_row_sel   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_dot_start <= 1'b0;
      r_row_valid <= 1'b0;
      r_row_value <= '0;
      r_results   <= '0;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_FINISH);
      r_dot_start <= (w_next == S_ISSUE);
      r_row_valid <= (w_next == S_STORE);
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_row_sel <= '0;
            r_error   <= 1'b0;
            r_cnt     <= '0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (bus.dot_done) begin
            r_row_value <= bus.dot_c;
            for (int i = 0; i < ROWS; i++) begin
              if (r_row_sel == RW'(i)) r_results[i] <= bus.dot_c;
            end
          end else if (w_timeout) begin
            r_error <= 1'b1;
          end
        end
        S_STORE: begin
          if (!w_last_row) begin
            r_row_sel <= r_row_sel + 1'b1;
            r_cnt     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.error     = r_error;
  assign bus.row_sel   = r_row_sel;
  assign bus.dot_start = r_dot_start;
  assign bus.row_valid = r_row_valid;
  assign bus.row_value = r_row_value;
  assign bus.results   = r_results;
endmodule

// File: doc/half_mat_v_sequencer.md
Name: half_mat_v_sequencer

Overview:
- Sequences one shared half-precision dot-product unit (start/done/c interface) to compute a matrix-vector product of ROWS rows.
- Per row: drives the row select, pulses the unit's start, waits for its done, and captures the 16-bit result into a result register array.
- Sits between the layer-level control FSM and the dot unit. The row-select output muxes matrix row `row_sel` onto the dot unit's vector_a, and the input vector drives vector_b.

Parameters:
- ROWS, 4, number of matrix rows, i.e. dot products per run (>=1).
- TIMEOUT, 64, maximum cycles spent in WAIT per row before abort (>=8).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rstn  input  1  synchronous active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a run ends (normal or abort).
- error  output  1  sticky timeout flag; cleared by next accepted start.
- row_sel  output  $clog2(ROWS+1)  row currently presented to dot unit.
- dot_start  output  1  start pulse to dot unit.
- dot_done  input  1  dot unit done level (stays high until next start).
- dot_c  input  16  dot unit result, valid while dot_done high.
- row_valid  output  1  one-cycle pulse, a row result was stored.
- row_value  output  16  result stored this cycle (valid with row_valid).
- results  output  16 x ROWS  registered result array, results[i] = row i.

Behaviour:
- Reset (rstn=0 at clock edge), all outputs registered:
  - state=IDLE, busy=0, done=0, error=0, row_sel=0, dot_start=0, row_valid=0, row_value=0, results[*]=0.
  - Reset overrides any state, including mid-run; no done pulse is generated.
- FSM states: IDLE, ISSUE, ARM, WAIT, STORE, FINISH.
- IDLE:
  - start=1 -> ISSUE, row_sel<=0, error<=0, timeout counter<=0.
  - start is ignored in all other states (no queueing).
- ISSUE (1 cycle): dot_start=1 this cycle only. -> ARM.
- ARM (1 cycle): dot_done is ignored, because the stale done from the previous row is still visible. -> WAIT.
- WAIT:
  - Timeout counter increments each cycle.
  - dot_done=1 -> STORE. Result captured on that edge: results[row_sel]<=dot_c, row_value<=dot_c, row_valid=1 during STORE.
  - If the counter reaches TIMEOUT-1 with dot_done=0 -> FINISH with error<=1. That row's results entry and all later entries keep their previous values.
  - dot_done has priority over timeout in the same cycle.
- STORE (1 cycle):
  - row_sel==ROWS-1 -> FINISH.
  - Otherwise row_sel<=row_sel+1, counter<=0 -> ISSUE.
- FINISH (1 cycle): done=1, busy=1. -> IDLE. start in FINISH is ignored.
- row_sel is stable from ISSUE through STORE of each row; it holds its last value in IDLE.
- Per-row overhead: ISSUE + ARM + STORE = 3 cycles plus dot-unit latency L. A dot_done first seen in the first WAIT cycle gives 4 cycles per row.
- Total run from start edge to done pulse: ROWS*(3+W)+1 cycles, where W = WAIT cycles per row (>=1).
- results hold until overwritten by a later run; they are not cleared by start.
- No arithmetic is performed on dot_c; values pass through bit-exact, including NaN and Inf encodings.

Test Plan:
1. Reset then idle: rstn=0 for 2 cycles, start=0 -> busy=0, done=0, error=0, results all 16'h0000, dot_start never pulses.
2. Normal run, ROWS=4, bench dot model asserts dot_done 14 cycles after dot_start with dot_c = 16'h3C00, 16'h4000, 16'hC200, 16'h0000 in row order:
   - exactly 4 dot_start pulses with row_sel 0,1,2,3;
   - 4 row_valid pulses carrying those values;
   - results = {3C00,4000,C200,0000};
   - single done pulse, error=0.
3. Stale done: the model holds dot_done=1 from the previous row until one cycle after dot_start -> no premature STORE; each row is stored only after its fresh done.
4. Timeout, TIMEOUT=64: the model never asserts done on row 2 ->
   - rows 0 and 1 are stored;
   - done pulses 64 cycles after entering WAIT for row 2;
   - error=1, results[2..3] unchanged.
   The next start clears error, and a full run then completes normally.
5. start held high throughout a run and during FINISH -> exactly one run, one done pulse; a new run begins only on start seen in IDLE.
6. Reset mid-run: rstn=0 during WAIT of row 1 -> next cycle IDLE, all outputs at reset values, no done pulse. A subsequent start runs from row 0.
